// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front-end storage: watchdog state
// encoding and the NOP constants loaded on reset, flush and bubble.
package pipe_pkg;

   localparam int CTRL_W_DEF = 10;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_ERR   = 2'd2
   } wd_state_t;

   localparam logic [31:0]           NOP_INST  = 32'h0000_0000;
   localparam logic [CTRL_W_DEF-1:0] CTRL_NOP  = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX control registers for the 5-stage core, driven by the
// hazard unit's stall/bubble controls and branch flush, with stall watchdog.
module pipe_front_regs
   import pipe_pkg::*;
#(
   parameter int          PC_W      = 32,
   parameter int          INST_W    = 32,
   parameter int          CTRL_W    = CTRL_W_DEF,
   parameter int          CNT_W     = 16,
   parameter int          MAX_STALL = 2,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_load,
   input  logic              IF_ID_load,
   input  logic              sel_signal,
   input  logic              flush,
   input  logic [PC_W-1:0]   pc_next,
   input  logic [INST_W-1:0] inst_if,
   input  logic [PC_W-1:0]   pc_plus4_if,
   input  logic [CTRL_W-1:0] ctrl_id,
   output logic [PC_W-1:0]   pc_out,
   output logic [INST_W-1:0] inst_id,
   output logic [PC_W-1:0]   pc_plus4_id,
   output logic              valid_id,
   output logic [CTRL_W-1:0] ctrl_ex,
   output logic              valid_ex,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count,
   output logic [CNT_W-1:0]  bubble_count,
   output logic              stall_err,
   output logic              proto_err
);

   // run must be able to hold MAX_STALL+1 to detect the overrun
   localparam int RUN_W = $clog2(MAX_STALL + 2);

   wd_state_t        r_state, w_state_nxt;
   logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
   logic             w_stall_err_nxt;
   logic             w_stall, w_bubble, w_proto;

   assign w_stall  = ~pc_load;
   assign w_bubble = ~sel_signal;
   assign w_proto  = (pc_load != IF_ID_load) | (~pc_load & sel_signal);
   assign w_run_inc = r_run + RUN_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_out      <= PC_W'(RESET_PC);
         inst_id     <= INST_W'(NOP_INST);
         pc_plus4_id <= '0;
         valid_id    <= 1'b0;
         ctrl_ex     <= CTRL_W'(CTRL_NOP);
         valid_ex    <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         if (pc_load) pc_out <= pc_next;

         if (flush) begin
            inst_id     <= INST_W'(NOP_INST);
            pc_plus4_id <= '0;
            valid_id    <= 1'b0;
         end else if (IF_ID_load) begin
            inst_id     <= inst_if;
            pc_plus4_id <= pc_plus4_if;
            valid_id    <= 1'b1;
         end

         if (sel_signal) begin
            ctrl_ex  <= ctrl_id;
            valid_ex <= valid_id;
         end else begin
            ctrl_ex  <= CTRL_W'(CTRL_NOP);
            valid_ex <= 1'b0;
         end

         if (w_proto) proto_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_RUN;
         r_run     <= '0;
         stall_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_run     <= w_run_nxt;
         stall_err <= w_stall_err_nxt;
      end
   end

   // Watchdog: flag only, the datapath above never consults it
   always_comb begin
      w_state_nxt     = r_state;
      w_run_nxt       = r_run;
      w_stall_err_nxt = stall_err;
      case (r_state)
         ST_RUN: begin
            if (w_stall) begin
               w_run_nxt   = RUN_W'(1);
               w_state_nxt = ST_STALL;
            end else begin
               w_run_nxt = '0;
            end
         end
         ST_STALL: begin
            if (w_stall) begin
               if (w_run_inc > RUN_W'(MAX_STALL)) begin
                  w_state_nxt     = ST_ERR;
                  w_stall_err_nxt = 1'b1;
               end
               w_run_nxt = w_run_inc;
            end else begin
               w_run_nxt   = '0;
               w_state_nxt = ST_RUN;
            end
         end
         ST_ERR: begin
            w_stall_err_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_run_nxt   = '0;
         end
      endcase
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk  (clk),
      .i_clr_n(rst),
      .i_inc  (w_stall),
      .o_count(stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .i_clk  (clk),
      .i_clr_n(rst),
      .i_inc  (flush),
      .o_count(flush_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .i_clk  (clk),
      .i_clr_n(rst),
      .i_inc  (w_bubble),
      .o_count(bubble_count)
   );

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs with narrow counters to reach saturation.
module tb_pipe_front_regs;

   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   localparam int CTRL_W = 10;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst, pc_load, IF_ID_load, sel_signal, flush;
   logic [PC_W-1:0]   pc_next, pc_plus4_if;
   logic [INST_W-1:0] inst_if;
   logic [CTRL_W-1:0] ctrl_id;
   logic [PC_W-1:0]   pc_out, pc_plus4_id;
   logic [INST_W-1:0] inst_id;
   logic              valid_id, valid_ex, stall_err, proto_err;
   logic [CTRL_W-1:0] ctrl_ex;
   logic [CNT_W-1:0]  stall_count, flush_count, bubble_count;

   int checks = 0;
   int errors = 0;

   pipe_front_regs #(
      .PC_W(PC_W), .INST_W(INST_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W),
      .MAX_STALL(2), .RESET_PC(0)
   ) dut (
      .clk(clk), .rst(rst), .pc_load(pc_load), .IF_ID_load(IF_ID_load),
      .sel_signal(sel_signal), .flush(flush), .pc_next(pc_next),
      .inst_if(inst_if), .pc_plus4_if(pc_plus4_if), .ctrl_id(ctrl_id),
      .pc_out(pc_out), .inst_id(inst_id), .pc_plus4_id(pc_plus4_id),
      .valid_id(valid_id), .ctrl_ex(ctrl_ex), .valid_ex(valid_ex),
      .stall_count(stall_count), .flush_count(flush_count),
      .bubble_count(bubble_count), .stall_err(stall_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ctl(input logic pl, input logic il, input logic sl, input logic fl);
      pc_load = pl; IF_ID_load = il; sel_signal = sl; flush = fl;
   endtask

   task automatic fetch(input logic [31:0] pn, input logic [31:0] ins,
                        input logic [31:0] p4, input logic [9:0] c);
      pc_next = pn; inst_if = ins; pc_plus4_if = p4; ctrl_id = c;
   endtask

   initial begin
      // Reset with random inputs
      rst = 1'b0;
      ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      fetch($urandom, $urandom, $urandom, 10'($urandom));
      tick();
      ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      chk("rst_pc", pc_out, 0);
      chk("rst_valid_id", valid_id, 0);
      chk("rst_valid_ex", valid_ex, 0);
      chk("rst_inst", inst_id, 0);
      chk("rst_ctrl", ctrl_ex, 0);
      chk("rst_stall_cnt", stall_count, 0);
      chk("rst_flush_cnt", flush_count, 0);
      chk("rst_bubble_cnt", bubble_count, 0);
      chk("rst_stall_err", stall_err, 0);
      chk("rst_proto_err", proto_err, 0);

      // Streaming
      rst = 1'b1;
      ctl(1, 1, 1, 0);
      fetch(32'h4, 32'h8C010000, 32'h4, 10'h155);
      tick();
      chk("s1_pc", pc_out, 32'h4);
      chk("s1_inst", inst_id, 32'h8C010000);
      chk("s1_p4", pc_plus4_id, 32'h4);
      chk("s1_valid_id", valid_id, 1);
      chk("s1_ctrl", ctrl_ex, 10'h155);
      chk("s1_valid_ex", valid_ex, 0);
      fetch(32'h8, 32'h8C010000, 32'h8, 10'h2AA);
      tick();
      chk("s2_pc", pc_out, 32'h8);
      chk("s2_p4", pc_plus4_id, 32'h8);
      chk("s2_ctrl", ctrl_ex, 10'h2AA);
      chk("s2_valid_ex", valid_ex, 1);
      fetch(32'hC, 32'h8C010000, 32'hC, 10'h0F0);
      tick();
      chk("s3_pc", pc_out, 32'hC);
      chk("s3_ctrl", ctrl_ex, 10'h0F0);
      chk("s3_stall_cnt", stall_count, 0);
      chk("s3_proto", proto_err, 0);

      // Load-use stall
      ctl(0, 0, 0, 0);
      fetch(32'h10, 32'h12345678, 32'h10, 10'h3FF);
      tick();
      chk("lu_pc", pc_out, 32'hC);
      chk("lu_inst", inst_id, 32'h8C010000);
      chk("lu_p4", pc_plus4_id, 32'hC);
      chk("lu_valid_id", valid_id, 1);
      chk("lu_ctrl", ctrl_ex, 0);
      chk("lu_valid_ex", valid_ex, 0);
      chk("lu_stall_cnt", stall_count, 1);
      chk("lu_bubble_cnt", bubble_count, 1);
      chk("lu_stall_err", stall_err, 0);
      chk("lu_proto", proto_err, 0);

      // Flush during stall
      ctl(0, 0, 0, 1);
      tick();
      chk("fl_inst", inst_id, 0);
      chk("fl_p4", pc_plus4_id, 0);
      chk("fl_valid_id", valid_id, 0);
      chk("fl_pc", pc_out, 32'hC);
      chk("fl_flush_cnt", flush_count, 1);
      chk("fl_stall_cnt", stall_count, 2);
      chk("fl_stall_err", stall_err, 0);

      // Resume
      ctl(1, 1, 1, 0);
      fetch(32'h10, 32'h00221820, 32'h10, 10'h0AB);
      tick();
      chk("rs_pc", pc_out, 32'h10);
      chk("rs_inst", inst_id, 32'h00221820);
      chk("rs_valid_id", valid_id, 1);
      chk("rs_ctrl", ctrl_ex, 10'h0AB);
      chk("rs_valid_ex", valid_ex, 0);
      chk("rs_stall_cnt", stall_count, 2);

      // Watchdog: three consecutive stalls trip it
      ctl(0, 0, 0, 0);
      fetch(32'h14, 32'hDEADBEEF, 32'h14, 10'h111);
      tick();
      chk("wd1_err", stall_err, 0);
      tick();
      chk("wd2_err", stall_err, 0);
      tick();
      chk("wd3_err", stall_err, 1);
      chk("wd3_stall_cnt", stall_count, 5);
      chk("wd3_pc", pc_out, 32'h10);
      ctl(1, 1, 1, 0);
      tick();
      chk("wd4_err_sticky", stall_err, 1);
      chk("wd4_pc", pc_out, 32'h14);
      chk("wd4_inst", inst_id, 32'hDEADBEEF);

      // Reset pulse clears flags
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rp_err", stall_err, 0);
      chk("rp_pc", pc_out, 0);
      chk("rp_stall_cnt", stall_count, 0);

      // Protocol: pc_load without IF_ID_load
      ctl(1, 0, 1, 0);
      fetch(32'h40, 32'h0, 32'h44, 10'h0);
      tick();
      chk("pr1_proto", proto_err, 1);
      chk("pr1_pc", pc_out, 32'h40);
      ctl(1, 1, 1, 0);
      tick();
      chk("pr1_sticky", proto_err, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("pr_rst", proto_err, 0);
      // Protocol: stall without bubble
      ctl(0, 0, 1, 0);
      tick();
      chk("pr2_proto", proto_err, 1);

      // Saturation
      rst = 1'b0;
      tick();
      rst = 1'b1;
      ctl(0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall_cnt", stall_count, 15);
      chk("sat_bubble_cnt", bubble_count, 15);
      chk("sat_flush_cnt", flush_count, 0);
      chk("sat_stall_err", stall_err, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
